uart_tx_feeder: RTL and testbench

Byte-buffering front end for the RS-232 transmitter. It accepts bytes from a producer (host logic, debug dumper) into an internal FIFO. It feeds them one at a time to the transmitter over that transmitter's level-held start protocol: `TxD_start` is held high until the transmitter reaches its end-of-frame state, then dropped to re-arm it. It sits directly upstream of the transmitter, and its `TxD_start`/`TxD_data` outputs connect to it with no glue logic.

---
 rtl/uart_tx_pkg.sv | 15 +
 rtl/sync_byte_fifo.sv | 85 ++++++++
 rtl/uart_tx_feeder.sv | 113 +++++++++++
 tb/tb_uart_tx_feeder.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and transmitter state encodings for the UART transmit feeder.
package uart_tx_pkg;

    // Feeder FSM states.
    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSend    = 2'd1,
        StRelease = 2'd2
    } feeder_state_e;

    // Transmitter state vector values the feeder reacts to.
    localparam logic [4:0] TX_ST_IDLE = 5'b00000;
    localparam logic [4:0] TX_ST_DONE = 5'b10000;

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO with byte count, synchronous flush and sticky overflow flag.
module sync_byte_fifo
    import uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              pop,
    input  logic              flush,
    input  logic              clr_overflow,
    output logic [7:0]        rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow
);

    localparam logic [ADDR_W:0] FullCnt = (ADDR_W + 1)'(DEPTH);

    logic [7:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              w_wr_ok;
    logic              w_pop_ok;

    // Flags come from the registered count only, so wr_en never reaches full combinationally.
    assign full     = (r_count == FullCnt);
    assign empty    = (r_count == '0);
    assign level    = r_count;
    assign overflow = r_overflow;
    assign rd_data  = r_mem[r_rd_ptr];

    assign w_wr_ok  = wr_en & ~full & ~flush;
    assign w_pop_ok = pop & ~empty & ~flush;

    // Storage write; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers and count; flush clears them and overrides any same-cycle write or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky overflow; a dropped write beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (wr_en && full) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to the transmitter using its level-held start handshake.
module uart_tx_feeder
    import uart_tx_pkg::*;
#(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    input  logic              flush,
    input  logic              clr_overflow,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              TxD_start,
    output logic [7:0]        TxD_data,
    input  logic [4:0]        tx_state,
    output logic              tx_done
);

    feeder_state_e r_state;
    feeder_state_e w_state_d;
    logic          r_start;
    logic          w_start_d;
    logic [7:0]    r_data;
    logic          r_done;
    logic          w_done_d;
    logic          w_pop;
    logic [7:0]    w_rd_data;

    sync_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .pop          (w_pop),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .rd_data      (w_rd_data),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow)
    );

    assign TxD_start = r_start;
    assign TxD_data  = r_data;
    assign tx_done   = r_done;

    // Next-state and pop decision; start stays high until the transmitter reports frame end.
    always_comb begin
        w_state_d = r_state;
        w_start_d = r_start;
        w_done_d  = 1'b0;
        w_pop     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!empty) begin
                    w_pop     = 1'b1;
                    w_start_d = 1'b1;
                    w_state_d = StSend;
                end
            end
            StSend: begin
                if (tx_state == TX_ST_DONE) begin
                    w_start_d = 1'b0;
                    w_done_d  = 1'b1;
                    w_state_d = StRelease;
                end
            end
            StRelease: begin
                // Re-arm only once the transmitter is back at idle.
                if (tx_state == TX_ST_IDLE) begin
                    if (!empty) begin
                        w_pop     = 1'b1;
                        w_start_d = 1'b1;
                        w_state_d = StSend;
                    end else begin
                        w_state_d = StIdle;
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_start_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops start at once, which aborts the transmitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= 8'h00;
        end else begin
            r_state <= w_state_d;
            r_start <= w_start_d;
            r_done  <= w_done_d;
            if (w_pop) begin
                r_data <= w_rd_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small level-start transmitter model.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
    import uart_tx_pkg::*;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int BIT    = 4;     // cycles per serial bit in the model
    localparam int LIMIT  = 4000;  // cycle bound on every wait

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             flush = 1'b0;
    logic             clr_overflow = 1'b0;
    logic             full;
    logic             empty;
    logic [ADDR_W:0]  level;
    logic             overflow;
    logic             TxD_start;
    logic [7:0]       TxD_data;
    logic [4:0]       tx_state;
    logic             tx_done;

    int total = 0;
    int bad = 0;

    uart_tx_feeder #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .flush        (flush),
        .clr_overflow (clr_overflow),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .overflow     (overflow),
        .TxD_start    (TxD_start),
        .TxD_data     (TxD_data),
        .tx_state     (tx_state),
        .tx_done      (tx_done)
    );

    always #50 clk = ~clk;  // 10 MHz

    // ---------------- transmitter model ----------------
    // States: 0 idle, 1 start bit, 2..9 data bits, 10..11 stop bits, 5'b10000 frame done.
    logic [4:0]  m_state = 5'd0;
    int          m_cnt = 0;
    logic [7:0]  m_data = 8'h00;
    logic [10:0] m_frame = '0;
    logic        m_line;
    logic        stall = 1'b0;
    int          m_aborts = 0;
    int          m_unstable = 0;
    logic [10:0] q_frames [$];

    assign tx_state = m_state;

    always_comb begin
        m_line = 1'b1;
        if (m_state == 5'd1) m_line = 1'b0;
        else if (m_state >= 5'd2 && m_state <= 5'd9) m_line = m_data[3'(m_state - 5'd2)];
    end

    always @(posedge clk) begin
        if (stall) begin
            m_state <= m_state;
        end else if (m_state == TX_ST_IDLE) begin
            if (TxD_start) begin
                m_state <= 5'd1;
                m_cnt   <= 0;
                m_data  <= TxD_data;
            end
        end else if (m_state == TX_ST_DONE) begin
            if (!TxD_start) m_state <= TX_ST_IDLE;
        end else if (!TxD_start) begin
            m_state  <= TX_ST_IDLE;
            m_aborts <= m_aborts + 1;
        end else begin
            if (TxD_data !== m_data) m_unstable <= m_unstable + 1;
            if (m_cnt == BIT - 1) begin
                m_cnt <= 0;
                m_frame[4'(m_state - 5'd1)] <= m_line;
                if (m_state == 5'd11) begin
                    m_state <= TX_ST_DONE;
                    q_frames.push_back({m_line, m_frame[9:0]});
                end else begin
                    m_state <= m_state + 5'd1;
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- monitor (negedge sampling) ----------------
    logic mon_clr = 1'b0;
    int   mon_done = 0;
    int   mon_rises = 0;
    int   min_gap = 1000;
    int   gap_run = 0;
    int   peak = 0;
    logic prev_start = 1'b0;
    logic seen_high = 1'b0;

    always @(negedge clk) begin
        if (mon_clr) begin
            mon_done   <= 0;
            mon_rises  <= 0;
            min_gap    <= 1000;
            gap_run    <= 0;
            peak       <= 0;
            seen_high  <= 1'b0;
            prev_start <= TxD_start;
        end else begin
            if (tx_done) mon_done <= mon_done + 1;
            if (int'(level) > peak) peak <= int'(level);
            if (TxD_start && !prev_start) begin
                mon_rises <= mon_rises + 1;
                if (seen_high && gap_run < min_gap) min_gap <= gap_run;
                gap_run <= 0;
            end
            if (TxD_start) seen_high <= 1'b1;
            else if (seen_high) gap_run <= gap_run + 1;
            prev_start <= TxD_start;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // Wait until `n` done pulses have been seen and the block is fully idle again.
    task automatic wait_drained(input int n, input string name);
        for (int i = 0; i < LIMIT * 4; i++) begin
            if (mon_done >= n && empty && tx_state == TX_ST_IDLE && dut.r_state == StIdle) break;
            tick();
        end
        total++;
        if (!(mon_done >= n && empty && dut.r_state == StIdle)) begin
            bad++;
            $display("FAIL %s_drain_timeout got done=%0d want=%0d", name, mon_done, n);
        end
        repeat (10) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #10 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (TxD_start !== 1'b0) begin bad++; $display("FAIL reset_start got=%0b want=0", TxD_start); end
        total++; if (TxD_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", TxD_data); end
        total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", tx_done); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", overflow); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", full); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0b want=1", empty); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int base;
        base = q_frames.size();
        clear_mon();
        write_byte(8'hA5);
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty_k got=%0b want=0", empty); end
        total++; if (TxD_start !== 1'b0) begin bad++; $display("FAIL single_start_k got=%0b want=0", TxD_start); end
        tick();
        total++; if (TxD_start !== 1'b1) begin bad++; $display("FAIL single_start_k1 got=%0b want=1", TxD_start); end
        total++; if (TxD_data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", TxD_data); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL single_level got=%0d want=0", level); end
        wait_drained(1, "single");
        total++; if (mon_done !== 1) begin bad++; $display("FAIL single_done_count got=%0d want=1", mon_done); end
        total++;
        if (q_frames.size() != base + 1) begin
            bad++; $display("FAIL single_frames got=%0d want=1", q_frames.size() - base);
        end else if (q_frames[base] !== 11'b11_10100101_0) begin
            bad++; $display("FAIL single_serial got=%b want=11101001010", q_frames[base]);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_end_empty got=%0b want=1", empty); end
    endtask

    task automatic test_burst();
        int base;
        int ab0;
        int un0;
        base = q_frames.size();
        ab0  = m_aborts;
        un0  = m_unstable;
        clear_mon();
        for (int i = 1; i <= 5; i++) write_byte(8'(i));
        wait_drained(5, "burst");
        total++; if (mon_done !== 5) begin bad++; $display("FAIL burst_done_count got=%0d want=5", mon_done); end
        total++; if (peak !== 4) begin bad++; $display("FAIL burst_peak_level got=%0d want=4", peak); end
        total++; if (min_gap !== 2) begin bad++; $display("FAIL burst_min_gap got=%0d want=2", min_gap); end
        total++; if (mon_rises !== 5) begin bad++; $display("FAIL burst_rises got=%0d want=5", mon_rises); end
        total++;
        if (q_frames.size() != base + 5) begin
            bad++; $display("FAIL burst_frames got=%0d want=5", q_frames.size() - base);
        end
        for (int i = 0; i < 5 && base + i < q_frames.size(); i++) begin
            total++;
            if (q_frames[base + i][8:1] !== 8'(i + 1)) begin
                bad++; $display("FAIL burst_order[%0d] got=%h want=%h", i, q_frames[base + i][8:1], i + 1);
            end
        end
        total++;
        if (m_aborts != ab0 || m_unstable != un0) begin
            bad++; $display("FAIL burst_protocol got aborts=%0d unstable=%0d want=0,0", m_aborts - ab0, m_unstable - un0);
        end
    endtask

    task automatic test_overflow();
        int base;
        base = q_frames.size();
        clear_mon();
        write_byte(8'hE0);
        for (int i = 0; i < LIMIT; i++) begin
            if (m_state == 5'b00100) break;
            tick();
        end
        total++; if (m_state !== 5'b00100) begin bad++; $display("FAIL ovf_reach_stall got=%b want=00100", m_state); end
        stall = 1'b1;
        for (int i = 0; i < 18; i++) write_byte(8'h10 + 8'(i));
        total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%0b want=1", full); end
        total++; if (level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d want=16", level); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
        // Dropped write and clear in the same cycle: the flag must stay set.
        wr_en = 1'b1; wr_data = 8'hAA; clr_overflow = 1'b1;
        tick();
        wr_en = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_clr_vs_drop got=%0b want=1", overflow); end
        tick();
        clr_overflow = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%0b want=0", overflow); end
        stall = 1'b0;
        wait_drained(17, "ovf");
        total++;
        if (q_frames.size() != base + 17) begin
            bad++; $display("FAIL ovf_frames got=%0d want=17", q_frames.size() - base);
        end else begin
            for (int i = 0; i < 17; i++) begin
                total++;
                if (q_frames[base + i][8:1] !== ((i == 0) ? 8'hE0 : 8'h10 + 8'(i - 1))) begin
                    bad++; $display("FAIL ovf_order[%0d] got=%h", i, q_frames[base + i][8:1]);
                end
            end
        end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL ovf_end_level got=%0d want=0", level); end
    endtask

    task automatic test_wrap();
        int base;
        int idx;
        base = q_frames.size();
        idx  = 0;
        clear_mon();
        for (int blk = 0; blk < 5; blk++) begin
            for (int j = 0; j < 8; j++) begin
                write_byte(8'(idx));
                idx++;
            end
            for (int i = 0; i < LIMIT; i++) begin
                if (level <= 5'd2) break;
                tick();
            end
            total++; if (level > 5'd2) begin bad++; $display("FAIL wrap_wait_level got=%0d want<=2", level); end
        end
        wait_drained(40, "wrap");
        total++;
        if (q_frames.size() != base + 40) begin
            bad++; $display("FAIL wrap_frames got=%0d want=40", q_frames.size() - base);
        end else begin
            for (int i = 0; i < 40; i++) begin
                total++;
                if (q_frames[base + i][8:1] !== 8'(i)) begin
                    bad++; $display("FAIL wrap_order[%0d] got=%h want=%h", i, q_frames[base + i][8:1], i);
                end
            end
        end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL wrap_level got=%0d want=0", level); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%0b want=0", overflow); end
    endtask

    task automatic test_flush();
        int base;
        int ab0;
        base = q_frames.size();
        ab0  = m_aborts;
        clear_mon();
        for (int i = 0; i < 4; i++) write_byte(8'hC1 + 8'(i));
        for (int i = 0; i < LIMIT; i++) begin
            if (m_state == 5'd5) break;
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (level !== 5'd0) begin bad++; $display("FAIL flush_level got=%0d want=0", level); end
        total++; if (TxD_start !== 1'b1) begin bad++; $display("FAIL flush_inflight got=%0b want=1", TxD_start); end
        wait_drained(1, "flush");
        repeat (100) tick();
        total++; if (mon_rises !== 1) begin bad++; $display("FAIL flush_rises got=%0d want=1", mon_rises); end
        total++;
        if (q_frames.size() != base + 1 || q_frames[base][8:1] !== 8'hC1) begin
            bad++; $display("FAIL flush_frame got=%0d frames want=1 of c1", q_frames.size() - base);
        end
        total++; if (m_aborts != ab0) begin bad++; $display("FAIL flush_abort got=%0d want=0", m_aborts - ab0); end
    endtask

    task automatic test_reset_mid();
        int base;
        int ab0;
        base = q_frames.size();
        ab0  = m_aborts;
        write_byte(8'h3C);
        for (int i = 0; i < LIMIT; i++) begin
            if (m_state == 5'b01010) break;
            tick();
        end
        total++; if (m_state !== 5'b01010) begin bad++; $display("FAIL rmid_reach got=%b want=01010", m_state); end
        @(negedge clk);
        #5 rst_n = 1'b0;
        #1;
        total++; if (TxD_start !== 1'b0) begin bad++; $display("FAIL rmid_async_start got=%0b want=0", TxD_start); end
        total++; if (TxD_data !== 8'h00) begin bad++; $display("FAIL rmid_data got=%h want=00", TxD_data); end
        total++; if (empty !== 1'b1 || level !== 5'd0) begin bad++; $display("FAIL rmid_fifo got empty=%0b level=%0d want=1,0", empty, level); end
        tick();
        total++; if (m_state !== 5'b00000) begin bad++; $display("FAIL rmid_tx_idle got=%b want=00000", m_state); end
        total++; if (m_aborts != ab0 + 1) begin bad++; $display("FAIL rmid_abort got=%0d want=1", m_aborts - ab0); end
        rst_n = 1'b1;
        repeat (5) tick();
        total++; if (TxD_start !== 1'b0 || tx_done !== 1'b0) begin bad++; $display("FAIL rmid_after got start=%0b done=%0b want=0,0", TxD_start, tx_done); end
        total++; if (q_frames.size() != base) begin bad++; $display("FAIL rmid_frames got=%0d want=0", q_frames.size() - base); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
